// File: rtl/mc_control_if.sv
// Bundle between the multicycle datapath and its control FSM: instruction fields and the
// ALU zero flag flow into the controller, enables and selects flow back out.
interface mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zf;

    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic [3:0] state;
    logic       illegal;

    // Datapath side: supplies instruction fields and flags, consumes controls.
    modport master (
        output opcode, funct, zf,
        input  pc_write, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
        input  alu_src_a, alu_src_b, pc_src, alu_op, state, illegal
    );

    // Controller side.
    modport slave (
        input  opcode, funct, zf,
        output pc_write, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
        output alu_src_a, alu_src_b, pc_src, alu_op, state, illegal
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM (lw, sw, R-type, beq, addi, j).
// Controls are decoded from the state register; only BRANCH pc_write (from zf), RTEX alu_op
// (from funct) and the illegal pulse look at live inputs. Reset gates every output low.
module mc_control (
    input  logic        clk,
    input  logic        rst,
    mc_control_if.slave bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtEx    = 4'd6,
        StRtWb    = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e     state_q, state_d;
    logic [3:0] rt_alu_op;
    logic       rt_legal;

    // Map R-type funct to an ALU operation; unknown functs fall back to ADD and are flagged.
    always_comb begin
        rt_legal  = 1'b1;
        rt_alu_op = 4'b0010;
        case (bus.funct)
            6'b100100: rt_alu_op = 4'b0000;
            6'b100101: rt_alu_op = 4'b0001;
            6'b100000: rt_alu_op = 4'b0010;
            6'b100010: rt_alu_op = 4'b0110;
            6'b101010: rt_alu_op = 4'b0111;
            6'b100111: rt_alu_op = 4'b1100;
            6'b000000: rt_alu_op = 4'b1111;
            default:   rt_legal  = 1'b0;
        endcase
    end

    // Next-state: opcode/funct are only consulted in DECODE, MEMADR and RTEX.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtEx;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StRtEx:   state_d = rt_legal ? StRtWb : StFetch;
            StAddiEx: state_d = StAddiWb;
            // MEMWB, MEMWR, RTWB, BRANCH, ADDIWB, JUMP and unused codes all return to FETCH.
            default:  state_d = StFetch;
        endcase
    end

    // State register; asynchronous reset lands in FETCH at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.state = state_q;

    // Control decode per state; everything held low while rst is asserted.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_src     = 2'b00;
        bus.alu_op     = 4'b0000;
        bus.illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    bus.ir_write  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = 4'b0010;
                    bus.pc_write  = 1'b1;
                end
                StDecode: begin
                    bus.alu_src_b = 2'b11;
                    bus.alu_op    = 4'b0010;
                    // Only an unknown opcode sends DECODE straight back to FETCH.
                    bus.illegal   = (state_d == StFetch);
                end
                StMemAdr, StAddiEx: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = 4'b0010;
                end
                StMemRd: bus.iord = 1'b1;
                StMemWb: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                end
                StRtEx: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = rt_alu_op;
                    bus.illegal   = !rt_legal;
                end
                StRtWb: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                StBranch: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 4'b0110;
                    bus.pc_src    = 2'b01;
                    bus.pc_write  = bus.zf;
                end
                StAddiWb: bus.reg_write = 1'b1;
                StJump: begin
                    bus.pc_src   = 2'b10;
                    bus.pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: a table of instructions with their expected state walk, expected
// per-cycle controls queued on a scoreboard and popped each cycle, plus reset-abort sequences.
module tb_mc_control;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mc_control_if bus ();

    mc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] state;
        ctrl_t      ctrl;
    } obs_t;

    // seq holds up to five state codes, first state in the top nibble.
    typedef struct {
        string      name;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       zf;
        int         n;
        logic [19:0] seq;
        logic [3:0] ex_alu;
        logic       ill;
    } vec_t;

    vec_t vecs [16];
    obs_t sb [$];
    int   applied = 0;
    int   miscompares = 0;

    // Expected controls for a state, written from the control table of the block.
    function automatic ctrl_t exp_ctrl(logic [3:0] s, logic zf, logic [3:0] ex_alu,
                                       logic ill_here);
        ctrl_t c = '0;
        case (s)
            4'd0: begin
                c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 4'b0010; c.pc_write = 1'b1;
            end
            4'd1: begin c.alu_src_b = 2'b11; c.alu_op = 4'b0010; end
            4'd2, 4'd9: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 4'b0010; end
            4'd3: c.iord = 1'b1;
            4'd4: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            4'd5: begin c.iord = 1'b1; c.mem_write = 1'b1; end
            4'd6: begin c.alu_src_a = 1'b1; c.alu_op = ex_alu; end
            4'd7: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            4'd8: begin
                c.alu_src_a = 1'b1; c.alu_op = 4'b0110; c.pc_src = 2'b01; c.pc_write = zf;
            end
            4'd10: c.reg_write = 1'b1;
            4'd11: begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            default: ;
        endcase
        c.illegal = ill_here;
        return c;
    endfunction

    function automatic obs_t mk(logic [3:0] s, logic zf, logic [3:0] ex_alu, logic ill_here);
        obs_t o;
        o.state = s;
        o.ctrl  = exp_ctrl(s, zf, ex_alu, ill_here);
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.state          = bus.state;
        o.ctrl.pc_write  = bus.pc_write;
        o.ctrl.ir_write  = bus.ir_write;
        o.ctrl.mem_write = bus.mem_write;
        o.ctrl.iord      = bus.iord;
        o.ctrl.reg_write = bus.reg_write;
        o.ctrl.reg_dst   = bus.reg_dst;
        o.ctrl.mem_to_reg = bus.mem_to_reg;
        o.ctrl.alu_src_a = bus.alu_src_a;
        o.ctrl.alu_src_b = bus.alu_src_b;
        o.ctrl.pc_src    = bus.pc_src;
        o.ctrl.alu_op    = bus.alu_op;
        o.ctrl.illegal   = bus.illegal;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = observe();
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got state=%0d ctrl=%h, want state=%0d ctrl=%h",
                     name, act.state, act.ctrl, exp.state, exp.ctrl);
        end
    endtask

    // Called at a falling edge with the FSM in FETCH; walks one instruction.
    task automatic run_vec(input vec_t v);
        logic [3:0] s;
        obs_t       e;
        bus.opcode = v.opcode;
        bus.funct  = v.funct;
        bus.zf     = v.zf;
        for (int k = 0; k < v.n; k++) begin
            s = v.seq[19 - 4 * k -: 4];
            sb.push_back(mk(s, v.zf, v.ex_alu, v.ill && (k == v.n - 1)));
        end
        for (int k = 0; k < v.n; k++) begin
            s = v.seq[19 - 4 * k -: 4];
            // Instruction fields are dead outside DECODE/MEMADR/RTEX; disturb them there.
            if (!(s inside {4'd0, 4'd1, 4'd2, 4'd6})) begin
                bus.opcode = 6'($urandom);
                bus.funct  = 6'($urandom);
            end
            #1;
            if (sb.size() == 0) begin
                miscompares++;
                applied++;
                $display("FAIL %s: scoreboard empty at cycle %0d, want an entry", v.name, k);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s_c%0d", v.name, k), e);
            end
            @(negedge clk);
        end
    endtask

    // Bounded wait (at falling edges) for a given state code.
    task automatic wait_state(input string name, input logic [3:0] s);
        int i;
        for (i = 0; i < 8; i++) begin
            if (bus.state == s) break;
            @(negedge clk);
        end
        if (i == 8) begin
            miscompares++;
            applied++;
            $display("FAIL %s: state %0d never reached, last state=%0d", name, s, bus.state);
        end
    endtask

    initial begin
        vecs[0]  = '{"lw",      6'b100011, 6'b000000, 1'b0, 5, 20'h01234, 4'b0000, 1'b0};
        vecs[1]  = '{"sw",      6'b101011, 6'b000000, 1'b0, 4, 20'h01250, 4'b0000, 1'b0};
        vecs[2]  = '{"slt",     6'b000000, 6'b101010, 1'b0, 4, 20'h01670, 4'b0111, 1'b0};
        vecs[3]  = '{"add",     6'b000000, 6'b100000, 1'b1, 4, 20'h01670, 4'b0010, 1'b0};
        vecs[4]  = '{"sub",     6'b000000, 6'b100010, 1'b0, 4, 20'h01670, 4'b0110, 1'b0};
        vecs[5]  = '{"and",     6'b000000, 6'b100100, 1'b0, 4, 20'h01670, 4'b0000, 1'b0};
        vecs[6]  = '{"or",      6'b000000, 6'b100101, 1'b0, 4, 20'h01670, 4'b0001, 1'b0};
        vecs[7]  = '{"nor",     6'b000000, 6'b100111, 1'b0, 4, 20'h01670, 4'b1100, 1'b0};
        vecs[8]  = '{"sll",     6'b000000, 6'b000000, 1'b0, 4, 20'h01670, 4'b1111, 1'b0};
        vecs[9]  = '{"badfn",   6'b000000, 6'b111111, 1'b0, 3, 20'h01600, 4'b0010, 1'b1};
        vecs[10] = '{"beq_t",   6'b000100, 6'b000000, 1'b1, 3, 20'h01800, 4'b0000, 1'b0};
        vecs[11] = '{"beq_nt",  6'b000100, 6'b000000, 1'b0, 3, 20'h01800, 4'b0000, 1'b0};
        vecs[12] = '{"addi",    6'b001000, 6'b000000, 1'b0, 4, 20'h019A0, 4'b0000, 1'b0};
        vecs[13] = '{"j",       6'b000010, 6'b000000, 1'b0, 3, 20'h01B00, 4'b0000, 1'b0};
        vecs[14] = '{"badop3f", 6'b111111, 6'b000000, 1'b0, 2, 20'h01000, 4'b0000, 1'b1};
        vecs[15] = '{"badop01", 6'b000001, 6'b000000, 1'b0, 2, 20'h01000, 4'b0000, 1'b1};

        bus.opcode = 6'b100011;
        bus.funct  = 6'b000000;
        bus.zf     = 1'b1;

        // Held in reset across clock edges: FETCH code, every control low.
        repeat (2) @(negedge clk);
        #1;
        check("reset_hold", '0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);
        #1;
        check("end_fetch", mk(4'd0, 1'b0, 4'b0000, 1'b0));
        @(negedge clk);

        // Reset in MEMWR kills the store immediately.
        bus.opcode = 6'b101011;
        wait_state("to_decode", 4'd1);
        wait_state("to_memwr", 4'd5);
        #1;
        check("memwr_live", mk(4'd5, 1'b0, 4'b0000, 1'b0));
        rst = 1'b1;
        #1;
        check("rst_in_memwr", '0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_held", '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("fetch_after_rst", mk(4'd0, 1'b0, 4'b0000, 1'b0));
        @(negedge clk);
        #1;
        check("decode_after_rst", mk(4'd1, 1'b0, 4'b0000, 1'b0));
        wait_state("sw_done", 4'd0);

        // Reset in a taken BRANCH drops pc_write mid-cycle.
        bus.opcode = 6'b000100;
        bus.zf     = 1'b1;
        @(negedge clk);
        wait_state("to_branch", 4'd8);
        rst = 1'b1;
        #1;
        check("rst_in_branch", '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("fetch_after_rst2", mk(4'd0, 1'b0, 4'b0000, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have a `clk` input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have an `rst` input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have an `opcode` input, 6 bits: instruction register bits [31:26].
REQ-004 The block SHALL have a `funct` input, 6 bits: instruction register bits [5:0].
REQ-005 The block SHALL have a `zf` input, 1 bit: ALU zero flag for the current cycle's result.
REQ-006 The block SHALL have a `pc_write` output, 1 bit: PC load enable.
REQ-007 The block SHALL have an `ir_write` output, 1 bit: instruction register load enable.
REQ-008 The block SHALL have `mem_write` and `iord` outputs, 1 bit each: data-memory write enable; address select (0 = PC, 1 = ALUOut).
REQ-009 The block SHALL have `reg_write`, `reg_dst` and `mem_to_reg` outputs, 1 bit each: register-file write enable; destination select (0 = rt, 1 = rd); writeback select (0 = ALUOut, 1 = MDR).
REQ-010 The block SHALL have an `alu_src_a` output, 1 bit: 0 = PC, 1 = register A.
REQ-011 The block SHALL have an `alu_src_b` output, 2 bits: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
REQ-012 The block SHALL have a `pc_src` output, 2 bits: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-013 The block SHALL have an `alu_op` output, 4 bits: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1111 SLL.
REQ-014 The block SHALL have a `state` output, 4 bits (current state, for debug) and an `illegal` output, 1 bit: one-cycle pulse on an unsupported instruction.

Function
REQ-015 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12–15 SHALL go to FETCH on the next edge.
REQ-016 Outputs SHALL be Moore (decoded from `state` only), except `pc_write` in BRANCH and `alu_op` in RTEX; every enable or select not listed for a state SHALL be 0.
REQ-017 In FETCH the block SHALL drive iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=0010, pc_src=00, pc_write=1, then go to DECODE.
REQ-018 In DECODE the block SHALL drive alu_src_a=0, alu_src_b=11, alu_op=0010 (branch target into ALUOut).
REQ-019 From DECODE the next state SHALL follow opcode: 100011 or 101011 -> MEMADR; 000000 -> RTEX; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> FETCH with illegal=1 for that DECODE cycle.
REQ-020 In MEMADR the block SHALL drive alu_src_a=1, alu_src_b=10, alu_op=0010, then go to MEMRD if opcode=100011, else MEMWR.
REQ-021 MEMRD SHALL drive iord=1 and go to MEMWB; MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1 and go to FETCH.
REQ-022 MEMWR SHALL drive iord=1, mem_write=1 and go to FETCH.
REQ-023 In RTEX the block SHALL drive alu_src_a=1 and alu_src_b=00, with alu_op from funct: 100100->0000, 100101->0001, 100000->0010, 100010->0110, 101010->0111, 100111->1100, 000000->1111.
REQ-024 An unsupported funct in RTEX SHALL drive alu_op=0010, pulse illegal, and go to FETCH, skipping RTWB.
REQ-025 RTWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0 and go to FETCH.
REQ-026 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=0110, pc_src=01, pc_write=zf (combinational in that cycle), then go to FETCH.
REQ-027 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=0010 and go to ADDIWB; ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0 and go to FETCH.
REQ-028 JUMP SHALL drive pc_src=10, pc_write=1 and go to FETCH.
REQ-029 Cycles from FETCH to the next FETCH SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2, illegal funct 3.
REQ-030 `opcode` and `funct` SHALL be sampled only in DECODE, MEMADR and RTEX; changes in other states SHALL have no effect.

Reset
REQ-031 While rst=1, state SHALL be FETCH and all outputs SHALL be 0 (pc_write, ir_write, mem_write, reg_write and illegal forced low), regardless of clk.
REQ-032 rst asserted mid-instruction SHALL abort it immediately with no further writes; after rst deasserts, the first rising edge SHALL execute FETCH with REQ-017 outputs.

Verification
REQ-033 Release rst, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4, with mem_to_reg=1.
REQ-034 opcode=000000, funct=101010 -> RTEX alu_op=0111; RTWB reg_write=1, reg_dst=1; 4 cycles total.
REQ-035 opcode=000100, zf=1 -> BRANCH pc_write=1, pc_src=01; repeat with zf=0 -> pc_write=0.
REQ-036 opcode=111111 -> illegal=1 in DECODE, next state FETCH; funct=111111 R-type -> illegal in RTEX, reg_write never 1.
REQ-037 Assert rst during MEMWR (state 5) -> mem_write drops to 0 immediately, state=0; after release, the FETCH cycle shows ir_write=1, pc_write=1.
REQ-038 opcode=000010 -> states 0,1,11,0 with pc_src=10, pc_write=1 in JUMP.
